// File: rtl/serial_reg_file_if.sv
// Serial access bus of the parametrised register file: frame strobes,
// serial data in/out, frame status and an FSM state tap.
interface serial_reg_file_if;
    logic       WR_EN;
    logic       RD_EN;
    logic       DIN;
    logic       DOUT;
    logic       BUSY;
    logic       ERR;
    logic [1:0] state_dbg;

    modport master (
        output WR_EN, RD_EN, DIN,
        input  DOUT, BUSY, ERR, state_dbg
    );

    modport slave (
        input  WR_EN, RD_EN, DIN,
        output DOUT, BUSY, ERR, state_dbg
    );
endinterface

// File: rtl/serial_reg_file.sv
// Parametrised serial-access register file.
// Frame protocol: WR_EN or RD_EN (exactly one) is sampled in IDLE at E0.
// BUSY then stays high for ADDR_WIDTH address bits plus DATA_WIDTH data bits.
// All serial data is MSB first on DIN/DOUT. A write frame commits the whole
// word at its last edge. A read frame drives DOUT from a registered shifter.
// ERR is a single-cycle pulse after a bad frame: write miss, write to a
// read-only reg, read miss, or both strobes asserted together in IDLE.
// Strobes seen while BUSY are ignored.
module serial_reg_file #(
    parameter int                            N_REG      = 5,
    parameter int                            DATA_WIDTH = 8,
    parameter int                            ADDR_WIDTH = 8,
    parameter logic [N_REG*ADDR_WIDTH-1:0]   ADDR_MAP   = {8'h55, 8'h06, 8'hA1, 8'h78, 8'h34},
    parameter logic [N_REG-1:0]              RO_MASK    = 5'b10000,
    parameter logic [N_REG*DATA_WIDTH-1:0]   RESET_VAL  = {8'h33, 8'h00, 8'h00, 8'h00, 8'h00}
) (
    input  logic                          CLK,
    input  logic                          RSTN,
    serial_reg_file_if.slave              bus,
    output logic [N_REG*DATA_WIDTH-1:0]   REG_Q
);

    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW   = $clog2(MAXW) + 1;
    localparam int IW   = (N_REG > 1) ? $clog2(N_REG) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_WDATA = 2'd2,
        S_RDATA = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   start_frame;
    logic                   both_err;
    logic                   phase_end;

    logic                   is_write;
    logic [CW-1:0]          cnt;
    logic [ADDR_WIDTH-2:0]  addr_shift;
    logic [DATA_WIDTH-2:0]  wr_shift;
    logic [DATA_WIDTH-2:0]  rd_shift;
    logic                   dout_q;
    logic                   err_q;
    logic                   hit_q;
    logic                   ro_q;
    logic [IW-1:0]          idx_q;

    logic [ADDR_WIDTH-1:0]  full_addr;
    logic                   dec_hit;
    logic [IW-1:0]          dec_idx;
    logic [DATA_WIDTH-1:0]  rd_val;
    logic                   commit_en;
    logic [DATA_WIDTH-1:0]  wr_word;

    assign phase_end = (cnt == '0);
    assign full_addr = {addr_shift, bus.DIN};
    assign rd_val    = REG_Q[dec_idx*DATA_WIDTH +: DATA_WIDTH];
    assign wr_word   = {wr_shift, bus.DIN};
    assign commit_en = (state == S_WDATA) && phase_end && hit_q && !ro_q;

    assign bus.DOUT      = dout_q;
    assign bus.BUSY      = (state != S_IDLE);
    assign bus.ERR       = err_q;
    assign bus.state_dbg = state;

    // Address decode; scanning from the top down lets the lowest index win on duplicates.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = N_REG - 1; i >= 0; i--) begin
            if (ADDR_MAP[i*ADDR_WIDTH +: ADDR_WIDTH] == full_addr) begin
                dec_hit = 1'b1;
                dec_idx = IW'(i);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and frame-level strobes.
    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        both_err    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.WR_EN && bus.RD_EN) begin
                    both_err = 1'b1;
                end else if (bus.WR_EN || bus.RD_EN) begin
                    start_frame = 1'b1;
                    state_next  = S_ADDR;
                end
            end
            S_ADDR: begin
                if (phase_end) begin
                    state_next = is_write ? S_WDATA : S_RDATA;
                end
            end
            S_WDATA, S_RDATA: begin
                if (phase_end) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: bit counter, shifters, decode capture, DOUT and ERR registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            is_write   <= 1'b0;
            cnt        <= '0;
            addr_shift <= '0;
            wr_shift   <= '0;
            rd_shift   <= '0;
            dout_q     <= 1'b0;
            err_q      <= 1'b0;
            hit_q      <= 1'b0;
            ro_q       <= 1'b0;
            idx_q      <= '0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    dout_q <= 1'b0;
                    if (both_err) begin
                        err_q <= 1'b1;
                    end
                    if (start_frame) begin
                        is_write <= bus.WR_EN;
                        cnt      <= CW'(ADDR_WIDTH - 1);
                    end
                end
                S_ADDR: begin
                    addr_shift <= (ADDR_WIDTH-1)'({addr_shift, bus.DIN});
                    if (phase_end) begin
                        cnt   <= CW'(DATA_WIDTH - 1);
                        hit_q <= dec_hit;
                        idx_q <= dec_idx;
                        ro_q  <= dec_hit && RO_MASK[dec_idx];
                        if (!is_write) begin
                            // First bit goes straight to DOUT; the rest wait in the shifter.
                            dout_q   <= dec_hit ? rd_val[DATA_WIDTH-1] : 1'b0;
                            rd_shift <= dec_hit ? rd_val[DATA_WIDTH-2:0] : '0;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_WDATA: begin
                    wr_shift <= (DATA_WIDTH-1)'({wr_shift, bus.DIN});
                    if (phase_end) begin
                        err_q <= !hit_q || ro_q;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_RDATA: begin
                    if (phase_end) begin
                        dout_q <= 1'b0;
                        err_q  <= !hit_q;
                    end else begin
                        dout_q   <= rd_shift[DATA_WIDTH-2];
                        rd_shift <= (DATA_WIDTH-1)'({rd_shift, 1'b0});
                        cnt      <= cnt - CW'(1);
                    end
                end
                default: dout_q <= 1'b0;
            endcase
        end
    end

    // Register storage: read-only regs are tied to their reset value, writable
    // regs load the staged word only at the commit edge.
    for (genvar g = 0; g < N_REG; g++) begin : g_reg
        if (RO_MASK[g]) begin : g_ro
            assign REG_Q[g*DATA_WIDTH +: DATA_WIDTH] = RESET_VAL[g*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_rw
            logic [DATA_WIDTH-1:0] q;
            // Commit the staged word when this reg is the decoded target.
            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    q <= RESET_VAL[g*DATA_WIDTH +: DATA_WIDTH];
                end else if (commit_en && (idx_q == IW'(g))) begin
                    q <= wr_word;
                end
            end
            assign REG_Q[g*DATA_WIDTH +: DATA_WIDTH] = q;
        end
    end

endmodule

// File: tb/tb_serial_reg_file.sv
// Bench for serial_reg_file: default 5x8/8-bit-address instance plus a
// 3x16/4-bit-address instance. Directed frames push expected read words, ERR
// values and REG_Q snapshots into queues; a negedge monitor pops and compares.
module tb_serial_reg_file;

    logic clk;
    logic rstn_a;
    logic rstn_b;
    logic sel;
    logic wr_en;
    logic rd_en;
    logic din;

    logic [39:0] regq_a;
    logic [47:0] regq_b;

    serial_reg_file_if ifa ();
    serial_reg_file_if ifb ();

    assign ifa.WR_EN = sel ? 1'b0 : wr_en;
    assign ifa.RD_EN = sel ? 1'b0 : rd_en;
    assign ifa.DIN   = sel ? 1'b0 : din;
    assign ifb.WR_EN = sel ? wr_en : 1'b0;
    assign ifb.RD_EN = sel ? rd_en : 1'b0;
    assign ifb.DIN   = sel ? din : 1'b0;

    serial_reg_file dut_a (
        .CLK   (clk),
        .RSTN  (rstn_a),
        .bus   (ifa),
        .REG_Q (regq_a)
    );

    serial_reg_file #(
        .N_REG      (3),
        .DATA_WIDTH (16),
        .ADDR_WIDTH (4),
        .ADDR_MAP   ({4'h9, 4'h5, 4'h2}),
        .RO_MASK    (3'b000),
        .RESET_VAL  (48'h0)
    ) dut_b (
        .CLK   (clk),
        .RSTN  (rstn_b),
        .bus   (ifb),
        .REG_Q (regq_b)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor view of whichever instance is selected
    logic        mon_rstn;
    logic        mon_busy;
    logic        mon_err;
    logic        mon_dout;
    logic [1:0]  mon_state;
    logic [63:0] mon_regq;

    assign mon_rstn  = sel ? rstn_b : rstn_a;
    assign mon_busy  = sel ? ifb.BUSY : ifa.BUSY;
    assign mon_err   = sel ? ifb.ERR : ifa.ERR;
    assign mon_dout  = sel ? ifb.DOUT : ifa.DOUT;
    assign mon_state = sel ? ifb.state_dbg : ifa.state_dbg;
    assign mon_regq  = sel ? {16'h0, regq_b} : {24'h0, regq_a};

    // Scoreboard
    logic [31:0] exp_q[$];
    logic        exp_err_q[$];
    logic [63:0] exp_regq_q[$];
    int total;
    int bad;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        total++;
        bad++;
        $display("FAIL %s: unexpected event, value %0h at %0t", name, act, $time);
    endtask

    // Driver: one frame starting at the next edge (E0). poke_edge raises WR_EN
    // before that edge mid-frame; abort_edge drops rstn_a before that edge.
    task automatic frame(input bit is_wr, input int aw, input int dw,
                         input logic [15:0] addr, input logic [31:0] data,
                         input int poke_edge, input int abort_edge);
        wr_en = is_wr;
        rd_en = !is_wr;
        @(posedge clk); #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        for (int e = 1; e <= aw + dw; e++) begin
            if (e == abort_edge) begin
                rstn_a = 1'b0;
                din    = 1'b0;
                return;
            end
            wr_en = (e == poke_edge);
            if (e <= aw)     din = addr[aw-e];
            else if (is_wr)  din = data[aw+dw-e];
            else             din = 1'b0;
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        din   = 1'b0;
    endtask

    task automatic push_rd(input logic [31:0] w, input logic e);
        exp_q.push_back(w);
        exp_err_q.push_back(e);
    endtask

    // Monitor
    logic        prev_busy;
    logic        prev_sel;
    logic [63:0] prev_regq;
    logic [31:0] rd_word;
    int          rd_cnt;
    logic        busy_fell;

    always @(negedge clk) begin
        if (!mon_rstn || (sel !== prev_sel)) begin
            prev_busy = 1'b0;
            prev_regq = mon_regq;
            prev_sel  = sel;
            rd_word   = '0;
            rd_cnt    = 0;
        end else begin
            busy_fell = prev_busy && !mon_busy;
            if (mon_state == 2'd3) begin
                rd_word = {rd_word[30:0], mon_dout};
                rd_cnt++;
            end else begin
                check("dout_idle", {63'h0, mon_dout}, 64'h0);
            end
            if (busy_fell && rd_cnt != 0) begin
                if (exp_q.size() == 0) unexpected("rd_word", {32'h0, rd_word});
                else check("rd_word", {32'h0, rd_word}, {32'h0, exp_q.pop_front()});
                rd_word = '0;
                rd_cnt  = 0;
            end
            if (mon_err || busy_fell) begin
                if (exp_err_q.size() == 0) unexpected("err", {63'h0, mon_err});
                else check("err", {63'h0, mon_err}, {63'h0, exp_err_q.pop_front()});
            end
            if (mon_regq !== prev_regq) begin
                if (exp_regq_q.size() == 0) unexpected("reg_q", mon_regq);
                else check("reg_q", mon_regq, exp_regq_q.pop_front());
                check("commit_edge", {63'h0, busy_fell}, 64'h1);
            end
            prev_busy = mon_busy;
            prev_regq = mon_regq;
        end
    end

    // Stimulus
    initial begin
        total  = 0;
        bad    = 0;
        sel    = 1'b0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        din    = 1'b0;
        rstn_a = 1'b0;
        rstn_b = 1'b0;
        prev_sel = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_regq_a", {24'h0, regq_a}, 64'h33_00_00_00_00);
        check("rst_regq_b", {16'h0, regq_b}, 64'h0);
        check("rst_dout",   {63'h0, ifa.DOUT}, 64'h0);
        check("rst_busy",   {63'h0, ifa.BUSY}, 64'h0);
        check("rst_err",    {63'h0, ifa.ERR},  64'h0);
        @(posedge clk); #1;
        rstn_a = 1'b1;
        rstn_b = 1'b1;
        @(posedge clk); #1;

        // Write 5C to A1 (reg 2), then read 55 (RO reg 4) and A1 back-to-back
        exp_err_q.push_back(1'b0);
        exp_regq_q.push_back(64'h33_00_5C_00_00);
        frame(1, 8, 8, 16'hA1, 32'h5C, 0, 0);
        push_rd(32'h33, 1'b0);
        frame(0, 8, 8, 16'h55, 32'h0, 0, 0);
        push_rd(32'h5C, 1'b0);
        frame(0, 8, 8, 16'hA1, 32'h0, 0, 0);

        // Write to RO reg and to an unmapped address: ERR, no commit
        exp_err_q.push_back(1'b1);
        frame(1, 8, 8, 16'h55, 32'hFF, 0, 0);
        exp_err_q.push_back(1'b1);
        frame(1, 8, 8, 16'h00, 32'h11, 0, 0);
        // Read miss returns zeros and ERR
        push_rd(32'h00, 1'b1);
        frame(0, 8, 8, 16'h00, 32'h0, 0, 0);

        // Write/read reg 1, read untouched reg 3
        exp_err_q.push_back(1'b0);
        exp_regq_q.push_back(64'h33_00_5C_A5_00);
        frame(1, 8, 8, 16'h78, 32'hA5, 0, 0);
        push_rd(32'hA5, 1'b0);
        frame(0, 8, 8, 16'h78, 32'h0, 0, 0);
        push_rd(32'h00, 1'b0);
        frame(0, 8, 8, 16'h06, 32'h0, 0, 0);

        // Both strobes together: no frame, ERR pulse
        exp_err_q.push_back(1'b1);
        wr_en = 1'b1;
        rd_en = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        check("both_busy", {63'h0, ifa.BUSY}, 64'h0);
        @(posedge clk); #1;
        // WR_EN pulsed at E5 of a read is ignored
        push_rd(32'h5C, 1'b0);
        frame(0, 8, 8, 16'hA1, 32'h0, 5, 0);

        // Reset at E12 of a write to 34: nothing committed
        frame(1, 8, 8, 16'h34, 32'h3C, 0, 12);
        @(negedge clk);
        check("midrst_dout", {63'h0, ifa.DOUT}, 64'h0);
        check("midrst_busy", {63'h0, ifa.BUSY}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rstn_a = 1'b1;
        @(negedge clk);
        check("midrst_regq", {24'h0, regq_a}, 64'h33_00_00_00_00);
        @(posedge clk); #1;
        exp_err_q.push_back(1'b0);
        exp_regq_q.push_back(64'h33_00_00_00_96);
        frame(1, 8, 8, 16'h34, 32'h96, 0, 0);
        push_rd(32'h96, 1'b0);
        frame(0, 8, 8, 16'h34, 32'h0, 0, 0);

        // Second instance: 3 regs x 16 bits, 4-bit addresses
        @(posedge clk); #1;
        sel = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        exp_err_q.push_back(1'b0);
        exp_regq_q.push_back(64'h0000_BEEF_0000);
        frame(1, 4, 16, 16'h5, 32'hBEEF, 0, 0);
        push_rd(32'hBEEF, 1'b0);
        frame(0, 4, 16, 16'h5, 32'h0, 0, 0);
        exp_err_q.push_back(1'b1);
        frame(1, 4, 16, 16'hF, 32'h1234, 0, 0);
        push_rd(32'h0000, 1'b0);
        frame(0, 4, 16, 16'h9, 32'h0, 0, 0);

        repeat (4) @(posedge clk);
        #1;
        check("rd_q_left",   64'(exp_q.size()), 64'h0);
        check("err_q_left",  64'(exp_err_q.size()), 64'h0);
        check("regq_q_left", 64'(exp_regq_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
